// File: rtl/four_bit_serial_addsub.sv
// Bit-serial 4-bit add/subtract unit with valid/ready handshakes on both sides.
// One full-adder slice processes the operands LSB first, one bit per clock.
module four_bit_serial_addsub (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   A,
   input  logic [3:0]   B,
   input  logic         Cin,
   input  logic         op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [3:0]   S,
   output logic         Cout,
   output logic         V,
   output logic         Z
);

   localparam int unsigned W  = 4;
   localparam int unsigned CW = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic          accept_c;
   logic          run_c;
   logic          last_c;

   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  res_sh;
   logic [CW-1:0] cnt;
   logic          carry;
   logic          c3;

   logic          bit_sum_c;
   logic          bit_carry_c;
   logic [W-1:0]  res_nxt_c;

   // Next-state decode
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      run_c     = 1'b0;
      last_c    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               accept_c  = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            run_c = 1'b1;
            if (cnt == CW'(W - 1)) begin
               last_c    = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_valid && out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register with registered handshake decodes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == ST_IDLE);
         out_valid <= (state_nxt == ST_DONE);
      end
   end

   // Single full-adder slice on the current LSBs
   always_comb begin
      bit_sum_c   = a_sh[0] ^ b_sh[0] ^ carry;
      bit_carry_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
      res_nxt_c   = {bit_sum_c, res_sh[W-1:1]};
   end

   // Operand shift registers, carry and bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         c3     <= 1'b0;
      end else if (accept_c) begin
         a_sh   <= A;
         b_sh   <= B ^ {W{op}};
         res_sh <= '0;
         cnt    <= '0;
         carry  <= Cin;
         c3     <= 1'b0;
      end else if (run_c) begin
         a_sh   <= {1'b0, a_sh[W-1:1]};
         b_sh   <= {1'b0, b_sh[W-1:1]};
         res_sh <= res_nxt_c;
         cnt    <= cnt + CW'(1);
         carry  <= bit_carry_c;
         if (cnt == CW'(W - 1)) begin
            c3 <= carry;
         end
      end
   end

   // Result and flags change only when the last bit completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S    <= '0;
         Cout <= 1'b0;
         V    <= 1'b0;
         Z    <= 1'b0;
      end else if (last_c) begin
         S    <= res_nxt_c;
         Cout <= bit_carry_c;
         V    <= carry ^ bit_carry_c;
         Z    <= (res_nxt_c == '0);
      end
   end

endmodule

// File: tb/tb_four_bit_serial_addsub.sv
// Randomized self-checking bench for four_bit_serial_addsub against an
// arithmetic reference model.
module tb_four_bit_serial_addsub;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] A;
   logic [3:0] B;
   logic       Cin;
   logic       op;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] S;
   logic       Cout;
   logic       V;
   logic       Z;

   int errors = 0;
   int checks = 0;

   // last completed result, {V,Z,Cout,S}
   logic [6:0] prev_res;

   four_bit_serial_addsub dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Cout      (Cout),
      .V         (V),
      .Z         (Z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic, overflow from the signed sum range
   function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic sub);
      int unsigned ua;
      int unsigned ub;
      int unsigned usum;
      int          sa;
      int          sb;
      int          ssum;
      logic [3:0]  s;
      logic        co;
      logic        v;
      ua   = a;
      ub   = sub ? (15 - int'(b)) : b;
      usum = ua + ub + cin;
      s    = 4'(usum % 16);
      co   = (usum >= 16);
      sa   = (ua >= 8) ? int'(ua) - 16 : int'(ua);
      sb   = (ub >= 8) ? int'(ub) - 16 : int'(ub);
      ssum = sa + sb + int'(cin);
      v    = (ssum > 7) || (ssum < -8);
      return {v, (s == 4'd0), co, s};
   endfunction

   function automatic logic [6:0] outs();
      return {V, Z, Cout, S};
   endfunction

   // One transaction; hold = cycles out_ready stays low after out_valid
   task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input logic cin,
                          input logic sub, input int hold);
      logic [6:0] exp;
      exp = model(a, b, cin, sub);
      chk("idle_in_ready", 8'(in_ready), 8'd1);
      A = a; B = b; Cin = cin; op = sub;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("accept_in_ready", 8'(in_ready), 8'd0);
      // operands change after the accept edge must have no effect
      A = 4'($urandom); B = 4'($urandom); Cin = 1'($urandom); op = 1'($urandom);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         if (k < 4) begin
            chk("run_out_valid", 8'(out_valid), 8'd0);
            chk("run_in_ready", 8'(in_ready), 8'd0);
            chk("run_hold_result", 8'(outs()), 8'(prev_res));
         end
      end
      chk("latency_out_valid", 8'(out_valid), 8'd1);
      chk("result", 8'(outs()), 8'(exp));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         A = 4'($urandom); B = 4'($urandom); Cin = 1'($urandom); op = 1'($urandom);
         @(posedge clk); #1;
         chk("bp_out_valid", 8'(out_valid), 8'd1);
         chk("bp_in_ready", 8'(in_ready), 8'd0);
         chk("bp_stable", 8'(outs()), 8'(exp));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("done_out_valid", 8'(out_valid), 8'd0);
      chk("done_in_ready", 8'(in_ready), 8'd1);
      chk("done_hold_result", 8'(outs()), 8'(exp));
      prev_res = exp;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; Cin = 1'b0; op = 1'b0;
      prev_res = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 8'(in_ready), 8'd1);
      chk("reset_out_valid", 8'(out_valid), 8'd0);
      chk("reset_result", 8'(outs()), 8'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_txn(4'b0010, 4'b0011, 1'b0, 1'b0, 0);
      run_txn(4'b1111, 4'b1111, 1'b1, 1'b0, 0);
      run_txn(4'b0111, 4'b0001, 1'b0, 1'b0, 1);
      run_txn(4'b0101, 4'b0011, 1'b1, 1'b1, 0);
      run_txn(4'b1000, 4'b0001, 1'b1, 1'b1, 0);
      run_txn(4'b0110, 4'b0110, 1'b1, 1'b1, 3);
      run_txn(4'b0110, 4'b0111, 1'b0, 1'b1, 0);

      // asynchronous reset after two RUN cycles
      A = 4'b1010; B = 4'b0101; Cin = 1'b1; op = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_in_ready", 8'(in_ready), 8'd1);
      chk("async_rst_out_valid", 8'(out_valid), 8'd0);
      chk("async_rst_result", 8'(outs()), 8'd0);
      prev_res = '0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_out_valid", 8'(out_valid), 8'd0);
      run_txn(4'b1101, 4'b0010, 1'b1, 1'b0, 0);

      for (int i = 0; i < 60; i++) begin
         run_txn(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
